hub75_capture: RTL and testbench

Receive-side counterpart of the HUB75 panel driver. Samples a HUB75 bus (as driven to a panel) and shifts in each row's serial colour bits, one line per strobe. It infers the row and bit-plane, then replays each latched line as a valid/ready write burst into a bit-plane frame store. Used for loopback verification of the panel driver and for daisy-chaining cube faces from an upstream controller.

---
 rtl/hub75_capture_if.sv | 23 ++
 rtl/hub75_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_hub75_capture.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_capture_if.sv
// rtl/hub75_capture_if.sv - Write-burst bus from the HUB75 capture block to a bit-plane frame store.
interface hub75_capture_if #(
    parameter int ROW_BITS   = 5,
    parameter int COL_BITS   = 6,
    parameter int PLANE_BITS = 3
);
    logic                         wr_valid;
    logic                         wr_ready;
    logic [ROW_BITS+COL_BITS-1:0] wr_addr;
    logic [PLANE_BITS-1:0]        wr_plane;
    logic [5:0]                   wr_data;
    logic                         frame_start;

    modport master (
        output wr_valid, wr_addr, wr_plane, wr_data, frame_start,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_plane, wr_data, frame_start,
        output wr_ready
    );
endinterface

// File: rtl/hub75_capture.sv
// rtl/hub75_capture.sv - Samples a HUB75 bus into two line banks and replays each line as a write burst.
// Optional HUB75_CAPTURE_STATS_EN adds frame_count and oe_on_cycles outputs.
module hub75_capture #(
    parameter int WIDTH        = 64,
    parameter int CHAIN_LENGTH = 1,
    parameter int ROW_BITS     = 5,
    parameter int COLOR_DEPTH  = 8,
    parameter int PLANE_BITS   = 3
) (
    input  logic display_clock,
    input  logic display_resetn,
    input  logic panel_r0,
    input  logic panel_g0,
    input  logic panel_b0,
    input  logic panel_r1,
    input  logic panel_g1,
    input  logic panel_b1,
    input  logic panel_a,
    input  logic panel_b,
    input  logic panel_c,
    input  logic panel_d,
    input  logic panel_e,
    input  logic panel_clk,
    input  logic panel_stb,
    input  logic panel_oe,
    hub75_capture_if.master wr,
    output logic overrun,
    output logic short_line
`ifdef HUB75_CAPTURE_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [23:0] oe_on_cycles
`endif
);
    localparam int LINE     = WIDTH * CHAIN_LENGTH;
    localparam int COL_BITS = $clog2(LINE);
    localparam int CNT_BITS = $clog2(LINE + 1);
    localparam logic [CNT_BITS-1:0]   LINE_CNT  = CNT_BITS'(LINE);
    localparam logic [PLANE_BITS-1:0] MAX_PLANE = PLANE_BITS'(COLOR_DEPTH - 1);

    typedef enum logic {IDLE, BURST} state_t;

    // {stb, clk, e..a, r1,g1,b1,r0,g0,b0}
    logic [12:0] sync1, sync2;
    logic        prev_clk, prev_stb;
    logic        clk_rise, stb_rise;
    logic [5:0]  s_color;
    logic [ROW_BITS-1:0] s_row;

    logic [CNT_BITS-1:0] col;
    logic                line_drop;
    logic                fill_sel, drain_sel;
    logic [1:0]          bank_full;
    logic [1:0][ROW_BITS-1:0]   bank_row;
    logic [1:0][PLANE_BITS-1:0] bank_plane;
    logic [1:0][CNT_BITS-1:0]   bank_count;
    logic [5:0]          bank_mem [2][LINE];
    logic [ROW_BITS-1:0] last_row;
    logic [PLANE_BITS-1:0] plane, plane_next;
    logic [COL_BITS-1:0] d;

    logic                col_write, mem_we;
    logic [CNT_BITS-1:0] line_count;
    logic                last_beat, free_bank;
    state_t              state, state_d;

    logic                        valid_c, fs_c;
    logic [ROW_BITS+COL_BITS-1:0] addr_c;
    logic [PLANE_BITS-1:0]       plane_c;
    logic [5:0]                  data_c;

    assign s_color  = sync2[5:0];
    assign s_row    = ROW_BITS'(sync2[10:6]);
    assign clk_rise = sync2[11] & ~prev_clk;
    assign stb_rise = sync2[12] & ~prev_stb;

    // Column count keeps running while the fill bank is occupied so short lines are still flagged.
    assign col_write  = clk_rise && (col != LINE_CNT);
    assign mem_we     = col_write && !bank_full[fill_sel];
    assign line_count = col + CNT_BITS'(col_write);
    assign last_beat  = (CNT_BITS'(d) == bank_count[drain_sel] - CNT_BITS'(1));

    always_comb begin
        plane_next = '0;
        if (s_row == last_row)
            plane_next = (plane == MAX_PLANE) ? plane : plane + PLANE_BITS'(1);
    end

    always_ff @(posedge display_clock or negedge display_resetn) begin
        if (!display_resetn) begin
            sync1    <= '0;
            sync2    <= '0;
            prev_clk <= 1'b0;
            prev_stb <= 1'b0;
        end else begin
            sync1    <= {panel_stb, panel_clk, panel_e, panel_d, panel_c, panel_b, panel_a,
                         panel_r1, panel_g1, panel_b1, panel_r0, panel_g0, panel_b0};
            sync2    <= sync1;
            prev_clk <= sync2[11];
            prev_stb <= sync2[12];
        end
    end

    always_ff @(posedge display_clock) begin
        if (mem_we)
            bank_mem[fill_sel][col[COL_BITS-1:0]] <= s_color;
    end

    always_ff @(posedge display_clock or negedge display_resetn) begin
        if (!display_resetn)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        free_bank = 1'b0;
        valid_c   = 1'b0;
        fs_c      = 1'b0;
        addr_c    = '0;
        plane_c   = '0;
        data_c    = '0;
        case (state)
            IDLE: begin
                if (bank_full[drain_sel]) begin
                    if (bank_count[drain_sel] == '0)
                        free_bank = 1'b1;
                    else
                        state_d = BURST;
                end
            end
            BURST: begin
                valid_c = 1'b1;
                addr_c  = {bank_row[drain_sel], d};
                plane_c = bank_plane[drain_sel];
                data_c  = bank_mem[drain_sel][d];
                fs_c    = (d == '0) && (bank_row[drain_sel] == '0) && (bank_plane[drain_sel] == '0);
                if (wr.wr_ready && last_beat) begin
                    free_bank = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr.wr_valid    = valid_c;
    assign wr.wr_addr     = addr_c;
    assign wr.wr_plane    = plane_c;
    assign wr.wr_data     = data_c;
    assign wr.frame_start = fs_c;

    always_ff @(posedge display_clock or negedge display_resetn) begin
        if (!display_resetn) begin
            col        <= '0;
            line_drop  <= 1'b0;
            fill_sel   <= 1'b0;
            drain_sel  <= 1'b0;
            bank_full  <= '0;
            bank_row   <= '0;
            bank_plane <= '0;
            bank_count <= '0;
            last_row   <= '1;
            plane      <= '0;
            d          <= '0;
            overrun    <= 1'b0;
            short_line <= 1'b0;
        end else begin
            if (state == BURST && wr.wr_ready)
                d <= last_beat ? '0 : d + COL_BITS'(1);

            if (free_bank) begin
                bank_full[drain_sel] <= 1'b0;
                drain_sel            <= ~drain_sel;
            end

            if (col_write)
                col <= col + CNT_BITS'(1);
            if (clk_rise && bank_full[fill_sel])
                line_drop <= 1'b1;

            // Banks are filled and drained in strict alternation, so drain_sel always holds the oldest line.
            if (stb_rise) begin
                last_row  <= s_row;
                plane     <= plane_next;
                col       <= '0;
                line_drop <= 1'b0;
                if (line_count != LINE_CNT)
                    short_line <= 1'b1;
                if (bank_full[fill_sel] || line_drop) begin
                    overrun <= 1'b1;
                end else begin
                    bank_full[fill_sel]  <= 1'b1;
                    bank_row[fill_sel]   <= s_row;
                    bank_plane[fill_sel] <= plane_next;
                    bank_count[fill_sel] <= line_count;
                    fill_sel             <= ~fill_sel;
                end
            end
        end
    end

`ifdef HUB75_CAPTURE_STATS_EN
    logic [1:0]  oe_sync;
    logic [23:0] oe_run;

    always_ff @(posedge display_clock or negedge display_resetn) begin
        if (!display_resetn) begin
            oe_sync      <= '0;
            oe_run       <= '0;
            oe_on_cycles <= '0;
            frame_count  <= '0;
        end else begin
            oe_sync <= {oe_sync[0], panel_oe};
            if (fs_c && wr.wr_ready)
                frame_count <= frame_count + 16'd1;
            if (stb_rise) begin
                oe_on_cycles <= oe_run + 24'(!oe_sync[1]);
                oe_run       <= '0;
            end else if (!oe_sync[1]) begin
                oe_run <= oe_run + 24'd1;
            end
        end
    end
`else
    logic unused_oe;
    assign unused_oe = panel_oe;
`endif
endmodule

// File: tb/tb_hub75_capture.sv
// tb/tb_hub75_capture.sv - Randomized self-checking bench for hub75_capture against a line-level model.
module tb_hub75_capture;
    localparam int LINE = 64;

    typedef struct packed {
        logic [10:0] addr;
        logic [2:0]  plane;
        logic [5:0]  data;
        logic        fs;
    } beat_t;

    logic display_clock = 1'b0;
    logic display_resetn;
    logic panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1;
    logic panel_a, panel_b, panel_c, panel_d, panel_e;
    logic panel_clk, panel_stb, panel_oe;
    logic overrun, short_line;
`ifdef HUB75_CAPTURE_STATS_EN
    logic [15:0] frame_count;
    logic [23:0] oe_on_cycles;
`endif

    hub75_capture_if #(.ROW_BITS(5), .COL_BITS(6), .PLANE_BITS(3)) wr_bus ();

    hub75_capture #(
        .WIDTH(64), .CHAIN_LENGTH(1), .ROW_BITS(5), .COLOR_DEPTH(8), .PLANE_BITS(3)
    ) dut (
        .display_clock(display_clock), .display_resetn(display_resetn),
        .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
        .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
        .panel_a(panel_a), .panel_b(panel_b), .panel_c(panel_c), .panel_d(panel_d), .panel_e(panel_e),
        .panel_clk(panel_clk), .panel_stb(panel_stb), .panel_oe(panel_oe),
        .wr(wr_bus), .overrun(overrun), .short_line(short_line)
`ifdef HUB75_CAPTURE_STATS_EN
        , .frame_count(frame_count), .oe_on_cycles(oe_on_cycles)
`endif
    );

    always #5 display_clock = ~display_clock;

    int total, bad, hold_viol, ready_mode;
    beat_t exp_q[$];
    beat_t got_q[$];
    logic [5:0] line_data [0:127];
    logic [4:0] m_last_row;
    int m_plane;
    bit m_short, m_over;

    task automatic step();
        @(posedge display_clock);
        #1;
    endtask

    initial begin
        wr_bus.wr_ready = 1'b0;
        forever begin
            step();
            case (ready_mode)
                0:       wr_bus.wr_ready = 1'b1;
                1:       wr_bus.wr_ready = ($urandom_range(0, 2) == 0);
                default: wr_bus.wr_ready = 1'b0;
            endcase
        end
    end

    initial begin
        beat_t cur, prev_b;
        bit prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge display_clock);
            if (!display_resetn) begin
                prev_stall = 1'b0;
            end else begin
                cur = {wr_bus.wr_addr, wr_bus.wr_plane, wr_bus.wr_data, wr_bus.frame_start};
                if (prev_stall && (!wr_bus.wr_valid || cur !== prev_b))
                    hold_viol++;
                if (wr_bus.wr_valid && wr_bus.wr_ready)
                    got_q.push_back(cur);
                prev_stall = wr_bus.wr_valid && !wr_bus.wr_ready;
                prev_b = cur;
            end
        end
    end

    // Line-level reference: plane from row repetition, beats only for captured columns.
    task automatic model_line(input logic [4:0] row, input int ncols, input bit drop);
        beat_t b;
        int n;
        m_plane = (row == m_last_row) ? ((m_plane < 7) ? m_plane + 1 : 7) : 0;
        m_last_row = row;
        if (ncols < LINE) m_short = 1'b1;
        if (drop) m_over = 1'b1;
        n = (ncols < LINE) ? ncols : LINE;
        if (!drop) begin
            for (int c = 0; c < n; c++) begin
                b.addr  = {row, 6'(c)};
                b.plane = 3'(m_plane);
                b.data  = line_data[c];
                b.fs    = (row == 5'd0) && (m_plane == 0) && (c == 0);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send_line(input logic [4:0] row, input int ncols, input bit pattern,
                             input bit drop, input bit coincide, output int lat);
        step();
        {panel_e, panel_d, panel_c, panel_b, panel_a} = row;
        panel_clk = 1'b0;
        for (int c = 0; c < ncols; c++) begin
            line_data[c] = pattern ? 6'(c) : 6'($urandom);
            step();
            {panel_r1, panel_g1, panel_b1, panel_r0, panel_g0, panel_b0} = line_data[c];
            panel_clk = 1'b0;
            panel_oe  = 1'($urandom);
            step();
            step();
            panel_clk = 1'b1;
            if (!(coincide && c == ncols - 1)) step();
        end
        if (!coincide || ncols == 0) begin
            step();
            panel_clk = 1'b0;
            step();
            step();
        end
        panel_stb = 1'b1;
        model_line(row, ncols, drop);
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (lat < 0 && wr_bus.wr_valid) lat = k;
            if (k == 2) begin
                panel_stb = 1'b0;
                panel_clk = 1'b0;
            end
        end
    endtask

    task automatic drain_wait(input string tag);
        int budget;
        budget = 0;
        while (got_q.size() < exp_q.size() && budget < 4000) begin
            step();
            budget++;
        end
        repeat (8) step();
        total++;
        if (budget >= 4000) begin
            bad++;
            $display("FAIL %s_drain_timeout got_beats=%0d required_beats=%0d", tag, got_q.size(), exp_q.size());
        end
    endtask

    function automatic int score_diffs();
        int n;
        n = (got_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        display_resetn = 1'b0;
        repeat (4) step();
        display_resetn = 1'b1;
        step();
        total += 7;
        if (wr_bus.wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%b required=0", wr_bus.wr_valid); end
        if (wr_bus.wr_addr !== 11'd0) begin bad++; $display("FAIL reset_wr_addr got=%h required=0", wr_bus.wr_addr); end
        if (wr_bus.wr_plane !== 3'd0) begin bad++; $display("FAIL reset_wr_plane got=%0d required=0", wr_bus.wr_plane); end
        if (wr_bus.wr_data !== 6'd0) begin bad++; $display("FAIL reset_wr_data got=%h required=0", wr_bus.wr_data); end
        if (wr_bus.frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%b required=0", wr_bus.frame_start); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b required=0", overrun); end
        if (short_line !== 1'b0) begin bad++; $display("FAIL reset_short_line got=%b required=0", short_line); end
    endtask

    task automatic test_basic();
        int lat, diffs;
        ready_mode = 0;
        send_line(5'd3, 64, 1'b1, 1'b0, 1'b0, lat);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d required=4", lat); end
        drain_wait("basic");
        diffs = score_diffs();
        total++;
        if (diffs !== 0) begin bad++; $display("FAIL basic_beats diffs=%0d required=0 got_n=%0d exp_n=%0d", diffs, got_q.size(), exp_q.size()); end
        total++;
        if (short_line !== 1'b0) begin bad++; $display("FAIL basic_short_line got=%b required=0", short_line); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_planes();
        int lat, diffs;
        int exp_planes[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 0};
        ready_mode = 0;
        send_line(5'd9, 64, 1'b0, 1'b0, 1'b0, lat);
        drain_wait("planes_pre");
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 11; i++) begin
            send_line((i < 10) ? 5'd3 : 5'd4, 64, 1'b0, 1'b0, 1'b0, lat);
            drain_wait("planes");
            total++;
            if (got_q.size() == 0 || int'(got_q[0].plane) !== exp_planes[i]) begin
                bad++;
                $display("FAIL plane_seq[%0d] got=%0d required=%0d", i, (got_q.size() == 0) ? -1 : int'(got_q[0].plane), exp_planes[i]);
            end
            diffs = score_diffs();
            total++;
            if (diffs !== 0) begin bad++; $display("FAIL planes_beats[%0d] diffs=%0d required=0", i, diffs); end
            got_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_frame_start();
        int lat, diffs, nfs;
        logic [4:0] rows[4] = '{5'd0, 5'd0, 5'd5, 5'd0};
        ready_mode = 0;
        foreach (rows[i]) begin
            send_line(rows[i], 64, 1'b0, 1'b0, 1'b0, lat);
            drain_wait("frame_start");
        end
        nfs = 0;
        foreach (got_q[i]) if (got_q[i].fs) nfs++;
        total++;
        if (nfs !== 2) begin bad++; $display("FAIL frame_start_count got=%0d required=2", nfs); end
        diffs = score_diffs();
        total++;
        if (diffs !== 0) begin bad++; $display("FAIL frame_start_beats diffs=%0d required=0", diffs); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int lat, diffs, viol0;
        viol0 = hold_viol;
        ready_mode = 1;
        for (int i = 0; i < 3; i++)
            send_line(5'($urandom_range(0, 31)), 64, 1'b0, 1'b0, 1'b0, lat);
        drain_wait("b2b");
        diffs = score_diffs();
        total++;
        if (diffs !== 0) begin bad++; $display("FAIL b2b_beats diffs=%0d required=0 got_n=%0d exp_n=%0d", diffs, got_q.size(), exp_q.size()); end
        total++;
        if (hold_viol !== viol0) begin bad++; $display("FAIL b2b_hold_stable violations=%0d required=0", hold_viol - viol0); end
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b required=0", overrun); end
        got_q.delete(); exp_q.delete();
        ready_mode = 0;
    endtask

    task automatic test_overrun();
        int lat, diffs;
        ready_mode = 2;
        repeat (3) step();
        for (int i = 0; i < 3; i++)
            send_line(5'($urandom_range(0, 31)), 64, 1'b0, (i == 2), 1'b0, lat);
        repeat (4) step();
        total++;
        if (overrun !== m_over) begin bad++; $display("FAIL overrun_flag got=%b required=%b", overrun, m_over); end
        ready_mode = 0;
        drain_wait("overrun");
        diffs = score_diffs();
        total++;
        if (diffs !== 0) begin bad++; $display("FAIL overrun_beats diffs=%0d required=0 got_n=%0d exp_n=%0d", diffs, got_q.size(), exp_q.size()); end
        total++;
        if (hold_viol !== 0) begin bad++; $display("FAIL overrun_hold_stable violations=%0d required=0", hold_viol); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_short_long();
        int lat, diffs;
        int ncols[4] = '{40, 70, 0, 64};
        ready_mode = 0;
        total++;
        if (short_line !== 1'b0) begin bad++; $display("FAIL short_before got=%b required=0", short_line); end
        foreach (ncols[i]) begin
            send_line(5'($urandom_range(0, 31)), ncols[i], 1'b0, 1'b0, (i == 0), lat);
            drain_wait("short_long");
            total++;
            if (short_line !== m_short) begin bad++; $display("FAIL short_flag[%0d] got=%b required=%b", i, short_line, m_short); end
            diffs = score_diffs();
            total++;
            if (diffs !== 0) begin bad++; $display("FAIL short_long_beats[%0d] diffs=%0d got_n=%0d exp_n=%0d", i, diffs, got_q.size(), exp_q.size()); end
            got_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_reset_midburst();
        int lat, diffs, budget;
        ready_mode = 1;
        send_line(5'd7, 64, 1'b0, 1'b0, 1'b0, lat);
        budget = 0;
        while (got_q.size() < 5 && budget < 500) begin step(); budget++; end
        total++;
        if (budget >= 500) begin bad++; $display("FAIL midburst_progress got_beats=%0d required>=5", got_q.size()); end
        #3;
        display_resetn = 1'b0;
        #1;
        total += 4;
        if (wr_bus.wr_valid !== 1'b0) begin bad++; $display("FAIL midburst_wr_valid got=%b required=0", wr_bus.wr_valid); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL midburst_overrun got=%b required=0", overrun); end
        if (short_line !== 1'b0) begin bad++; $display("FAIL midburst_short_line got=%b required=0", short_line); end
        if (wr_bus.wr_addr !== 11'd0) begin bad++; $display("FAIL midburst_wr_addr got=%h required=0", wr_bus.wr_addr); end
        repeat (3) step();
        display_resetn = 1'b1;
        got_q.delete(); exp_q.delete();
        m_last_row = 5'h1f; m_plane = 0; m_short = 1'b0; m_over = 1'b0;
        ready_mode = 0;
        send_line(5'h1f, 64, 1'b0, 1'b0, 1'b0, lat);
        drain_wait("post_reset");
        diffs = score_diffs();
        total++;
        if (diffs !== 0) begin bad++; $display("FAIL post_reset_beats diffs=%0d got_n=%0d exp_n=%0d", diffs, got_q.size(), exp_q.size()); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        total = 0; bad = 0; hold_viol = 0; ready_mode = 0;
        m_last_row = 5'h1f; m_plane = 0; m_short = 1'b0; m_over = 1'b0;
        {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} = '0;
        {panel_a, panel_b, panel_c, panel_d, panel_e} = '0;
        panel_clk = 1'b0; panel_stb = 1'b0; panel_oe = 1'b1;
        test_reset();
        test_basic();
        test_planes();
        test_frame_start();
        test_back_to_back();
        test_overrun();
        test_short_long();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
